// File: rtl/sprite_move_ctrl.sv
// rtl/sprite_move_ctrl.sv - debounced direction keys move a sprite one step per frame during vsync
module sprite_move_ctrl #(
  parameter int DEB_CYCLES = 250000,
  parameter int STEP       = 2,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int X_INIT     = 304,
  parameter int Y_INIT     = 224
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       vs,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [3:0] key_state,
  output logic       moving,
  output logic       frame_done
);

  localparam logic [10:0] X_LIM    = 11'(X_MAX - SPR_W + 1);
  localparam logic [10:0] Y_LIM    = 11'(Y_MAX - SPR_H + 1);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [17:0] DEB_LAST = 18'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {WAIT, APPLY_X, APPLY_Y} state_t;

  state_t      state, state_d;
  logic [3:0]  key_s1, key_s2;
  logic        vs_s1, vs_s2, vs_prev;
  logic [17:0] deb_cnt [4];
  logic [3:0]  snap, snap_d;
  logic [9:0]  x_d, y_d;
  logic        x_moved, x_moved_d, moving_d, frame_done_d;
  logic        frame_start;

  assign frame_start = ~vs_s2 & vs_prev;

  // Saturating one-axis step; 11-bit math keeps both ends from wrapping.
  function automatic logic [9:0] axis_step(input logic [9:0] pos, input logic dec,
                                           input logic inc, input logic [10:0] lim);
    logic [10:0] p;
    logic [9:0]  r;
    p = {1'b0, pos};
    r = pos;
    if (dec && !inc)
      r = (p >= STEP11) ? 10'(p - STEP11) : 10'd0;
    else if (inc && !dec)
      r = (p + STEP11 > lim) ? lim[9:0] : 10'(p + STEP11);
    return r;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_s1  <= 4'hf;
      key_s2  <= 4'hf;
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      key_s1  <= {up, down, left, right};
      key_s2  <= key_s1;
      vs_s1   <= vs;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;
    end
  end

  // key_state holds the accepted pressed flag; raw keys are active-low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_state <= 4'h0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (~key_s2[i] == key_state[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          key_state[i] <= ~key_state[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 18'd1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state;
    snap_d       = snap;
    x_d          = x_pos;
    y_d          = y_pos;
    x_moved_d    = x_moved;
    moving_d     = moving;
    frame_done_d = 1'b0;
    case (state)
      WAIT: begin
        if (frame_start) begin
          snap_d  = key_state;
          state_d = APPLY_X;
        end
      end
      APPLY_X: begin
        x_d       = axis_step(x_pos, snap[1], snap[0], X_LIM);
        x_moved_d = (x_d != x_pos);
        state_d   = APPLY_Y;
      end
      APPLY_Y: begin
        y_d          = axis_step(y_pos, snap[3], snap[2], Y_LIM);
        moving_d     = x_moved | (y_d != y_pos);
        frame_done_d = 1'b1;
        state_d      = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= WAIT;
      snap       <= 4'h0;
      x_pos      <= 10'(X_INIT);
      y_pos      <= 10'(Y_INIT);
      x_moved    <= 1'b0;
      moving     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      snap       <= snap_d;
      x_pos      <= x_d;
      y_pos      <= y_d;
      x_moved    <= x_moved_d;
      moving     <= moving_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
